// File: rtl/npu_ahb_slave_if.sv
// AHB-Lite single-transfer slave front end: legality check, then one outstanding register request.
// Latency: 1 wait state with a zero-wait backend; each backend stall cycle adds one more.
// Backpressure: hready_o is held low while reg_ready_i is low; errors use the two-cycle ERROR response.
module npu_ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          REG_AW    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ahb_haddr_i,
    input  logic              ahb_hwrite_i,
    input  logic [2:0]        ahb_hsize_i,
    input  logic [2:0]        ahb_hburst_i,
    input  logic [3:0]        ahb_hprot_i,
    input  logic [1:0]        ahb_htrans_i,
    input  logic              ahb_hmastlock_i,
    input  logic [31:0]       ahb_hwdata_i,
    output logic              ahb_hready_o,
    output logic              ahb_hresp_o,
    output logic [31:0]       ahb_hrdata_o,
    output logic              reg_req_o,
    output logic              reg_we_o,
    output logic [REG_AW-3:0] reg_addr_o,
    output logic [3:0]        reg_be_o,
    output logic [31:0]       reg_wdata_o,
    input  logic [31:0]       reg_rdata_i,
    input  logic              reg_ready_i,
    input  logic              reg_err_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [31:0] WIN_END = BASE_ADDR + (32'd1 << REG_AW);

    state_t              state_q, state_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [REG_AW-3:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;

    logic [31:0]         offset;
    logic                in_win;
    logic                aligned;
    logic                legal;
    logic [3:0]          be_calc;

    // Burst/protection/lock attributes carry no meaning for a register window.
    logic unused_ok;
    assign unused_ok = ^{ahb_hburst_i, ahb_hprot_i, ahb_hmastlock_i,
                         offset[31:REG_AW], offset[1:0], ahb_htrans_i[0]};

    always_comb begin
        offset  = ahb_haddr_i - BASE_ADDR;
        in_win  = (ahb_haddr_i >= BASE_ADDR) && (ahb_haddr_i < WIN_END);
        aligned = 1'b0;
        be_calc = 4'b0000;
        case (ahb_hsize_i)
            3'd0: begin
                aligned = 1'b1;
                be_calc = 4'b0001 << ahb_haddr_i[1:0];
            end
            3'd1: begin
                aligned = ~ahb_haddr_i[0];
                be_calc = 4'b0011 << {ahb_haddr_i[1], 1'b0};
            end
            3'd2: begin
                aligned = (ahb_haddr_i[1:0] == 2'b00);
                be_calc = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                be_calc = 4'b0000;
            end
        endcase
        legal = in_win && aligned;
    end

    always_comb begin
        state_d  = state_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        hrdata_d = hrdata_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        case (state_q)
            // Every state that shows hready=1 can accept the next address phase.
            ST_IDLE, ST_RESP, ST_ERR2: begin
                if (ahb_htrans_i[1]) begin
                    if (legal) begin
                        state_d  = ST_ACCESS;
                        hready_d = 1'b0;
                        hresp_d  = 1'b0;
                        req_d    = 1'b1;
                        we_d     = ahb_hwrite_i;
                        addr_d   = offset[REG_AW-1:2];
                        be_d     = be_calc;
                    end else begin
                        state_d  = ST_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                        req_d    = 1'b0;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    hready_d = 1'b1;
                    hresp_d  = 1'b0;
                    req_d    = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (reg_ready_i) begin
                    req_d = 1'b0;
                    if (reg_err_i) begin
                        state_d  = ST_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                    end else begin
                        state_d  = ST_RESP;
                        hready_d = 1'b1;
                        hresp_d  = 1'b0;
                        if (!we_q) begin
                            hrdata_d = reg_rdata_i;
                        end
                    end
                end
            end
            ST_ERR1: begin
                state_d  = ST_ERR2;
                hready_d = 1'b1;
                hresp_d  = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= 32'h0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
        end
    end

    assign ahb_hready_o = hready_q;
    assign ahb_hresp_o  = hresp_q;
    assign ahb_hrdata_o = hrdata_q;
    assign reg_req_o    = req_q;
    assign reg_we_o     = we_q;
    assign reg_addr_o   = addr_q;
    assign reg_be_o     = be_q;
    // The master holds HWDATA for the whole stalled data phase, so no capture is needed.
    assign reg_wdata_o  = ahb_hwdata_i;

endmodule

// File: tb/tb_npu_ahb_slave_if.sv
// Randomized bench for npu_ahb_slave_if against a transfer-level reference model.
module tb_npu_ahb_slave_if;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          AW   = 12;
    localparam logic [31:0] WIN  = 32'd1 << AW;

    logic          clk;
    logic          reset;
    logic [31:0]   ahb_haddr_i;
    logic          ahb_hwrite_i;
    logic [2:0]    ahb_hsize_i;
    logic [2:0]    ahb_hburst_i;
    logic [3:0]    ahb_hprot_i;
    logic [1:0]    ahb_htrans_i;
    logic          ahb_hmastlock_i;
    logic [31:0]   ahb_hwdata_i;
    logic          ahb_hready_o;
    logic          ahb_hresp_o;
    logic [31:0]   ahb_hrdata_o;
    logic          reg_req_o;
    logic          reg_we_o;
    logic [AW-3:0] reg_addr_o;
    logic [3:0]    reg_be_o;
    logic [31:0]   reg_wdata_o;
    logic [31:0]   reg_rdata_i;
    logic          reg_ready_i;
    logic          reg_err_i;

    npu_ahb_slave_if #(.BASE_ADDR(BASE), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ahb_haddr_i(ahb_haddr_i), .ahb_hwrite_i(ahb_hwrite_i), .ahb_hsize_i(ahb_hsize_i),
        .ahb_hburst_i(ahb_hburst_i), .ahb_hprot_i(ahb_hprot_i), .ahb_htrans_i(ahb_htrans_i),
        .ahb_hmastlock_i(ahb_hmastlock_i), .ahb_hwdata_i(ahb_hwdata_i),
        .ahb_hready_o(ahb_hready_o), .ahb_hresp_o(ahb_hresp_o), .ahb_hrdata_o(ahb_hrdata_o),
        .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_be_o(reg_be_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .reg_ready_i(reg_ready_i),
        .reg_err_i(reg_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: transfer legality, byte lanes and read-data history.
    logic [31:0] exp_rdata = 32'h0;

    function automatic bit model_legal(input logic [31:0] a, input logic [2:0] sz);
        if (a < BASE) return 1'b0;
        if (a - BASE >= WIN) return 1'b0;
        if (sz > 3'd2) return 1'b0;
        return (a % (32'd1 << sz)) == 32'd0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] sz);
        int n, lo;
        logic [3:0] be;
        n  = 1 << sz;
        lo = (int'(a % 32'd4) / n) * n;
        be = 4'b0000;
        for (int b = 0; b < 4; b++) be[b] = (b >= lo) && (b < lo + n);
        return be;
    endfunction

    // Backend: answers each request after bk_delay stall cycles; noise on its inputs otherwise.
    int          bk_delay = 0;
    bit          bk_err   = 1'b0;
    logic [31:0] bk_rdata = 32'h0;
    int          bk_cnt   = 0;
    int          req_cycles = 0;
    int          req_count  = 0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    initial begin
        reg_ready_i = 1'b0;
        reg_err_i   = 1'b0;
        reg_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (reg_req_o === 1'b1) begin
                if (bk_cnt == 0) begin
                    req_count++;
                    cap_we    = reg_we_o;
                    cap_addr  = 32'(reg_addr_o);
                    cap_be    = reg_be_o;
                    cap_wdata = reg_wdata_o;
                end
                req_cycles++;
                reg_ready_i = (bk_cnt >= bk_delay);
                reg_err_i   = reg_ready_i ? bk_err : 1'($urandom);
                reg_rdata_i = reg_ready_i ? bk_rdata : $urandom;
                bk_cnt++;
            end else begin
                bk_cnt      = 0;
                reg_ready_i = 1'($urandom);
                reg_err_i   = 1'($urandom);
                reg_rdata_i = $urandom;
            end
        end
    end

    // One transfer, entered on a negedge while hready_o=1; returns on the completing negedge.
    task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [31:0] wd, input int dly, input bit er,
                        input logic [31:0] rd, output int cyc);
        bit lg, exp_err;
        int waits, rc0, rq0, exp_waits;
        logic last_resp;
        lg        = model_legal(a, sz);
        exp_err   = !lg || er;
        exp_waits = !lg ? 1 : (er ? dly + 2 : dly + 1);
        bk_delay = dly; bk_err = er; bk_rdata = rd;
        rc0 = req_cycles; rq0 = req_count;
        ahb_haddr_i = a; ahb_hwrite_i = w; ahb_hsize_i = sz; ahb_htrans_i = 2'b10;
        ahb_hburst_i = 3'($urandom); ahb_hprot_i = 4'($urandom); ahb_hmastlock_i = 1'($urandom);
        @(posedge clk);
        #1;
        ahb_htrans_i = 2'($urandom_range(0, 1));
        ahb_haddr_i  = $urandom;
        ahb_hwdata_i = wd;
        waits = 0;
        last_resp = 1'b0;
        do begin
            @(negedge clk);
            if (ahb_hready_o !== 1'b1) begin
                waits++;
                last_resp = ahb_hresp_o;
            end
        end while (ahb_hready_o !== 1'b1 && waits < 64);
        chk("wait_states", 32'(waits), 32'(exp_waits));
        chk("hresp_last_wait", 32'(last_resp), 32'(exp_err));
        chk("hresp_final", 32'(ahb_hresp_o), 32'(exp_err));
        chk("req_count", 32'(req_count - rq0), 32'(lg));
        chk("req_cycles", 32'(req_cycles - rc0), lg ? 32'(dly + 1) : 32'd0);
        if (lg) begin
            chk("reg_we", 32'(cap_we), 32'(w));
            chk("reg_addr", cap_addr, (a - BASE) >> 2);
            chk("reg_be", 32'(cap_be), 32'(model_be(a, sz)));
            chk("reg_wdata", cap_wdata, wd);
            if (!er && !w) exp_rdata = rd;
        end
        chk("hrdata", ahb_hrdata_o, exp_rdata);
        cyc = waits + 1;
    endtask

    // IDLE/BUSY cycles: zero-wait OKAY and no backend request.
    task automatic idle_gap(input int n);
        int rq0;
        rq0 = req_count;
        for (int i = 0; i < n; i++) begin
            ahb_htrans_i = 2'($urandom_range(0, 1));
            ahb_haddr_i  = BASE + $urandom_range(0, 64);
            @(negedge clk);
            chk("idle_hready", 32'(ahb_hready_o), 32'd1);
            chk("idle_hresp", 32'(ahb_hresp_o), 32'd0);
        end
        chk("idle_no_req", 32'(req_count - rq0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c1, c2;
        logic [31:0] a;
        logic [2:0] sz;
        reset = 1'b1;
        ahb_haddr_i = 32'h0; ahb_hwrite_i = 1'b0; ahb_hsize_i = 3'd0; ahb_hburst_i = 3'd0;
        ahb_hprot_i = 4'd0; ahb_htrans_i = 2'b00; ahb_hmastlock_i = 1'b0; ahb_hwdata_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_hready", 32'(ahb_hready_o), 32'd1);
        chk("rst_hresp", 32'(ahb_hresp_o), 32'd0);
        chk("rst_hrdata", ahb_hrdata_o, 32'd0);
        chk("rst_req", 32'(reg_req_o), 32'd0);
        chk("rst_we", 32'(reg_we_o), 32'd0);
        chk("rst_addr", 32'(reg_addr_o), 32'd0);
        chk("rst_be", 32'(reg_be_o), 32'd0);
        reset = 1'b0;
        idle_gap(2);

        xfer(BASE + 32'h004, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0, c);
        xfer(BASE + 32'h010, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h1234_5678, c);
        chk("read_hrdata", ahb_hrdata_o, 32'h1234_5678);
        xfer(BASE + 32'h007, 1'b1, 3'd0, 32'hAA00_0000, 0, 1'b0, 32'h0, c);
        chk("byte_be", 32'(cap_be), 32'h8);
        xfer(BASE + 32'h002, 1'b1, 3'd1, 32'h5555_0000, 1, 1'b0, 32'h0, c);
        chk("half_be", 32'(cap_be), 32'hC);
        xfer(BASE + 32'h001, 1'b1, 3'd1, 32'h1, 0, 1'b0, 32'h0, c);
        xfer(BASE + 32'h000, 1'b0, 3'd3, 32'h2, 0, 1'b0, 32'h0, c);
        xfer(BASE + WIN, 1'b0, 3'd2, 32'h3, 0, 1'b0, 32'h0, c);
        xfer(BASE + WIN - 4, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D, c);
        xfer(BASE - 4, 1'b1, 3'd2, 32'h4, 0, 1'b0, 32'h0, c);
        xfer(BASE + 32'h020, 1'b0, 3'd2, 32'h0, 1, 1'b1, 32'hBAD0_BAD0, c);
        idle_gap(1);

        xfer(BASE + 32'h030, 1'b1, 3'd2, 32'h0A0A_0A0A, 0, 1'b0, 32'h0, c1);
        xfer(BASE + 32'h034, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h7777_1111, c2);
        chk("b2b_cycles", 32'(c1 + c2), 32'd4);
        chk("b2b_second_addr", cap_addr, 32'hD);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                7:       a = BASE + WIN + $urandom_range(0, 255);
                8:       a = BASE - 1 - $urandom_range(0, 255);
                9:       a = $urandom;
                default: a = BASE + $urandom_range(0, int'(WIN) - 1);
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer(a, 1'($urandom), sz, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0, $urandom, c);
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
        end

        // Reset while the backend is stalled in the middle of an access.
        bk_delay = 1000;
        ahb_haddr_i = BASE + 32'h040; ahb_hwrite_i = 1'b0; ahb_hsize_i = 3'd2; ahb_htrans_i = 2'b10;
        @(posedge clk);
        #1 ahb_htrans_i = 2'b00;
        @(negedge clk);
        chk("mid_req_before_rst", 32'(reg_req_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(reg_req_o), 32'd0);
        chk("mid_rst_hready", 32'(ahb_hready_o), 32'd1);
        chk("mid_rst_hresp", 32'(ahb_hresp_o), 32'd0);
        chk("mid_rst_hrdata", ahb_hrdata_o, 32'd0);
        exp_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        idle_gap(3);
        xfer(BASE + 32'h044, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
